// File: rtl/video_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_sync_pkg
// Description : Shared types and helpers for the video_sync_delay block:
//               timing-bus struct, FSM state type, delay clamping and
//               pointer / config width derivation.
// Revision    : 1.0 - initial release
// ============================================================================
package video_sync_pkg;

  // Timing signals carried alongside the pixel bus (vs in the MSB).
  typedef struct packed {
    logic vs;
    logic hs;
    logic de;
  } sync_bus_t;

  // FILL : buffer refilling, outputs blanked.
  // RUN  : delayed data passed through, locked asserted.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } sync_state_e;

  // Default geometry, handy for callers that do not override parameters.
  localparam int DEFAULT_MAX_DELAY = 32;

  // Pointer width into a buffer of max_delay entries (at least one bit).
  function automatic int ptr_width(input int max_delay);
    int w;
    w = (max_delay > 1) ? $clog2(max_delay) : 1;
    return w;
  endfunction

  // Width of a delay value able to hold 0..2*max_delay-1.
  function automatic int cfg_width(input int max_delay);
    int w;
    w = ptr_width(max_delay) + 1;
    return w;
  endfunction

  localparam int DEFAULT_PTR_W = ptr_width(DEFAULT_MAX_DELAY);
  localparam int DEFAULT_CFG_W = cfg_width(DEFAULT_MAX_DELAY);

  // Map a requested delay onto the legal range 1..max_delay.
  function automatic int unsigned clamp_delay(input int unsigned cfg,
                                              input int unsigned max_delay);
    int unsigned d;
    if (cfg == 0) begin
      d = 1;
    end else if (cfg > max_delay) begin
      d = max_delay;
    end else begin
      d = cfg;
    end
    return d;
  endfunction

endpackage : video_sync_pkg
`default_nettype wire

// File: rtl/video_sync_delay_ram.sv
`default_nettype none
// ============================================================================
// Module      : sync_delay_ram
// Description : Simple dual-port buffer, DEPTH x WIDTH, synchronous write and
//               synchronous read. A read of the address written on the same
//               edge returns the new data (write-first), which the delay line
//               relies on for its shortest buffered delay.
// Ports       : clk      - clock
//               i_we     - write enable
//               i_waddr  - write address
//               i_wdata  - write data
//               i_re     - read enable (read register holds when low)
//               i_raddr  - read address
//               o_rdata  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module sync_delay_ram
  import video_sync_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int WIDTH  = 27,
  parameter int ADDR_W = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage is intentionally not reset; only entries written after a reset
  // are ever presented as valid data.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      if (i_we && (i_waddr == i_raddr)) begin
        r_rdata <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_raddr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule : sync_delay_ram
`default_nettype wire

// File: rtl/video_sync_delay.sv
`default_nettype none
// ============================================================================
// Module      : video_sync_delay
// Description : Runtime-programmable delay line for vs/hs/de plus a pixel
//               bus, built on a circular buffer. Outputs are blanked while the
//               buffer refills after reset or a delay change; locked reports
//               valid delayed data, cfg_pending an outstanding delay change.
// Options     : SYNC_DELAY_FRAME_ALIGN_EN - when defined, a pending delay
//               change is applied only on a rising (to active) vs_in edge.
// Ports       : clk          - clock
//               reset        - asynchronous, active-high reset
//               en           - pixel-clock enable, all state advances on en
//               delay_cfg    - requested delay in enabled cycles
//               vs_in/hs_in/de_in/pix_in     - timing and pixel input
//               vs_out/hs_out/de_out/pix_out - delayed timing and pixel
//               locked       - outputs carry valid delayed data
//               cfg_pending  - delay change requested but not yet applied
// Revision    : 1.0 - initial release
// ============================================================================
module video_sync_delay
  import video_sync_pkg::*;
#(
  parameter int MAX_DELAY        = 32,
  parameter int DEFAULT_DELAY    = 9,
  parameter int DATA_W           = 24,
  parameter int SYNC_ACTIVE_HIGH = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [$clog2(MAX_DELAY):0] delay_cfg,
  input  logic                       vs_in,
  input  logic                       hs_in,
  input  logic                       de_in,
  input  logic [DATA_W-1:0]          pix_in,
  output logic                       vs_out,
  output logic                       hs_out,
  output logic                       de_out,
  output logic [DATA_W-1:0]          pix_out,
  output logic                       locked,
  output logic                       cfg_pending
);

  localparam int                  c_PTR_W     = ptr_width(MAX_DELAY);
  localparam int                  c_CFG_W     = cfg_width(MAX_DELAY);
  localparam int                  c_WORD_W    = DATA_W + 3;
  localparam logic                c_ACT       = (SYNC_ACTIVE_HIGH != 0);
  localparam logic                c_INACT     = !c_ACT;
  localparam logic [c_CFG_W-1:0]  c_ONE_D     = c_CFG_W'(1);
  localparam logic [c_CFG_W-1:0]  c_DEF_D     = c_CFG_W'(DEFAULT_DELAY);
  localparam logic [c_PTR_W-1:0]  c_DEF_CNT   = c_PTR_W'(DEFAULT_DELAY - 1);
  localparam sync_state_e         c_RST_STATE = (DEFAULT_DELAY == 1) ? RUN : FILL;
  localparam sync_bus_t           c_BLANK_SYNC = '{vs: c_INACT, hs: c_INACT, de: 1'b0};

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  sync_state_e          r_state;
  logic [c_PTR_W-1:0]   r_wp;
  logic [c_PTR_W-1:0]   r_cnt;
  logic [c_CFG_W-1:0]   r_d;
  logic                 r_init;
  logic                 r_pend;
  logic [c_CFG_W-1:0]   r_pend_val;
  sync_bus_t            r_out_sync;
  logic [DATA_W-1:0]    r_out_pix;
  logic                 r_locked;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  sync_state_e          w_state_next;
  logic [c_PTR_W-1:0]   w_cnt_next;
  logic [c_CFG_W-1:0]   w_req;
  logic                 w_apply;
  logic [c_CFG_W-1:0]   w_d_next;
  logic [c_PTR_W-1:0]   w_d_low;
  logic [c_PTR_W-1:0]   w_raddr;
  sync_bus_t            w_sync_in;
  logic [c_WORD_W-1:0]  w_wdata;
  logic [c_WORD_W-1:0]  w_rdata;
  sync_bus_t            w_src_sync;
  logic [DATA_W-1:0]    w_src_pix;
  sync_bus_t            w_out_sync;
  logic [DATA_W-1:0]    w_out_pix;
  logic                 w_out_locked;

  // --------------------------------------------------------------------------
  // Delay change request / application
  // --------------------------------------------------------------------------
  assign w_req = c_CFG_W'(clamp_delay(32'(delay_cfg), MAX_DELAY));

`ifdef SYNC_DELAY_FRAME_ALIGN_EN
  logic r_vs_prev;
  logic w_vs_rise;

  // Previous enabled vs sample; reset to inactive so an already-active vs
  // after reset counts as a frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vs_prev <= c_INACT;
    end else if (en) begin
      r_vs_prev <= vs_in;
    end
  end

  assign w_vs_rise = (vs_in == c_ACT) && (r_vs_prev != c_ACT);
  assign w_apply   = r_pend && w_vs_rise;
`else
  assign w_apply   = r_pend;
`endif

  // Delay in force after this edge; the read address and D=1 bypass use it
  // so that the first output after a change already reflects the new delay.
  assign w_d_next = w_apply ? r_pend_val : r_d;

  // Requests are compared against the delay in force after this edge: a
  // request equal to it is dropped, otherwise the latest value is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d        <= c_DEF_D;
      r_pend     <= 1'b0;
      r_pend_val <= c_DEF_D;
    end else if (en) begin
      r_d        <= w_d_next;
      r_pend     <= (w_req != w_d_next);
      r_pend_val <= w_req;
    end
  end

  // --------------------------------------------------------------------------
  // Circular buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp <= '0;
    end else if (en) begin
      r_wp <= r_wp + c_PTR_W'(1);
    end
  end

  assign w_sync_in = '{vs: vs_in, hs: hs_in, de: de_in};
  assign w_wdata   = {w_sync_in, pix_in};

  // The RAM read register plus the output register add one stage beyond the
  // nominal wp-(D-1) index, so the read runs one entry ahead: wp-D+2. For
  // D=2 that is the entry being written, served by the write-first read.
  assign w_d_low = w_d_next[c_PTR_W-1:0];
  assign w_raddr = r_wp - w_d_low + c_PTR_W'(2);

  sync_delay_ram #(
    .DEPTH  (MAX_DELAY),
    .WIDTH  (c_WORD_W),
    .ADDR_W (c_PTR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (en),
    .i_waddr (r_wp),
    .i_wdata (w_wdata),
    .i_re    (en),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // D=1 is a single register stage, so the input bypasses the buffer.
  always_comb begin
    w_src_sync = w_sync_in;
    w_src_pix  = pix_in;
    if (w_d_next != c_ONE_D) begin
      {w_src_sync, w_src_pix} = w_rdata;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_RST_STATE;
      r_cnt   <= c_DEF_CNT;
      r_init  <= 1'b1;
    end else if (en) begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_init  <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // The first enabled edge after reset plays the role of the apply edge, so
  // the counter is not decremented on it.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (w_apply) begin
      w_cnt_next   = c_PTR_W'(r_pend_val - c_ONE_D);
      w_state_next = (r_pend_val == c_ONE_D) ? RUN : FILL;
    end else if ((r_state == FILL) && !r_init) begin
      if (r_cnt <= c_PTR_W'(1)) begin
        w_state_next = RUN;
        w_cnt_next   = '0;
      end else begin
        w_cnt_next   = r_cnt - c_PTR_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (blanking mux ahead of the output register)
  // --------------------------------------------------------------------------
  always_comb begin
    w_out_sync   = c_BLANK_SYNC;
    w_out_pix    = '0;
    w_out_locked = 1'b0;
    if (w_state_next == RUN) begin
      w_out_sync   = w_src_sync;
      w_out_pix    = w_src_pix;
      w_out_locked = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_sync <= c_BLANK_SYNC;
      r_out_pix  <= '0;
      r_locked   <= 1'b0;
    end else if (en) begin
      r_out_sync <= w_out_sync;
      r_out_pix  <= w_out_pix;
      r_locked   <= w_out_locked;
    end
  end

  assign vs_out      = r_out_sync.vs;
  assign hs_out      = r_out_sync.hs;
  assign de_out      = r_out_sync.de;
  assign pix_out     = r_out_pix;
  assign locked      = r_locked;
  assign cfg_pending = r_pend;

endmodule : video_sync_delay
`default_nettype wire
